pip_stage_elastic: RTL and testbench

PIP_STAGE_ELASTIC -- requirements
Module: pip_stage_elastic

---
 rtl/pip_pkg.sv | 33 +++
 rtl/pip_sat_cnt.sv | 31 +++
 rtl/pip_stage_elastic.sv | 157 +++++++++++++++
 tb/tb_pip_stage_elastic.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pip_pkg
// Description : Shared types and default widths for the elastic pipeline
//               stages (decode / execute boundary).
// Revision    : 1.0 - initial release
// ============================================================================
package pip_pkg;

  localparam int unsigned c_data_w = 128;
  localparam int unsigned c_ctrl_w = 16;
  localparam int unsigned c_cnt_w  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_t;

  // Control bundle carried alongside an instruction; packs to c_ctrl_w bits.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_control;
    logic       alu_src;
    logic [4:0] rd;
  } pip_ctrl_t;

endpackage : pip_pkg
`default_nettype wire

// File: rtl/pip_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pip_sat_cnt
// Description : Parametrised up-counter that saturates at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module pip_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule : pip_sat_cnt
`default_nettype wire

// File: rtl/pip_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pip_stage_elastic
// Description : Valid/ready pipeline register with optional two-entry skid
//               buffer, synchronous flush and back-pressure stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pip_stage_elastic
  import pip_pkg::*;
#(
  parameter int unsigned DATA_W  = c_data_w,
  parameter int unsigned CTRL_W  = c_ctrl_w,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = c_cnt_w
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  stage_state_t r_state;
  stage_state_t w_state_nxt;

  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_valid;
  logic w_ready;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_load_in;
  logic w_load_skid;
  logic w_pop_skid;
  logic w_clr_ctrl;

  assign w_valid    = (r_state != EMPTY);
  assign w_in_xfer  = valid_i && w_ready;
  assign w_out_xfer = w_valid && ready_i;

  generate
    if (SKID_EN != 0) begin : g_ready_skid
      // Registered ready: depends only on the next state, never on ready_i.
      logic r_ready;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_ready <= 1'b1;
        end else begin
          r_ready <= (w_state_nxt != SKID);
        end
      end
      assign w_ready = r_ready;
    end else begin : g_ready_pass
      assign w_ready = !w_valid || ready_i;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_load_in   = 1'b0;
    w_load_skid = 1'b0;
    w_pop_skid  = 1'b0;
    w_clr_ctrl  = 1'b0;
    if (flush_i) begin
      w_state_nxt = EMPTY;
      w_clr_ctrl  = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = FULL;
            w_load_in   = 1'b1;
          end
        end
        FULL: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_in = 1'b1;
          end else if (w_in_xfer && (SKID_EN != 0)) begin
            w_state_nxt = SKID;
            w_load_skid = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = EMPTY;
            w_clr_ctrl  = 1'b1;
          end
        end
        SKID: begin
          if (w_out_xfer) begin
            w_state_nxt = FULL;
            w_pop_skid  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_clr_ctrl  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Main ctrl is cleared whenever the stage empties so a bubble reads as NOP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_in) begin
        r_main_ctrl <= ctrl_i;
        r_main_data <= data_i;
      end else if (w_pop_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end else if (w_clr_ctrl) begin
        r_main_ctrl <= '0;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= ctrl_i;
        r_skid_data <= data_i;
      end
    end
  end

  pip_sat_cnt #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_inc  (w_valid && !ready_i),
    .o_cnt  (stall_cnt_o)
  );

  assign ready_o = w_ready;
  assign valid_o = w_valid;
  assign ctrl_o  = r_main_ctrl;
  assign data_o  = r_main_data;

endmodule : pip_stage_elastic
`default_nettype wire

// File: tb/tb_pip_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : tb_pip_stage_elastic
// Description : Scoreboard bench for pip_stage_elastic (skid variant, 4-bit
//               stall counter) against a two-deep FIFO reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pip_stage_elastic;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned NW = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          valid_i;
  logic          ready_o;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;
  logic          flush_i;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic [NW-1:0] stall_cnt_o;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } word_t;

  word_t sb[$];
  int    exp_cnt = 0;
  int    n_cmp   = 0;
  int    n_err   = 0;

  pip_stage_elastic #(
    .DATA_W  (DW),
    .CTRL_W  (CW),
    .SKID_EN (1),
    .CNT_W   (NW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .ctrl_i      (ctrl_i),
    .data_i      (data_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .ctrl_o      (ctrl_o),
    .data_o      (data_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT against the FIFO model, then advances the model
  // using the inputs that will be seen at the coming rising edge.
  initial begin
    bit room;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        check("rst_valid", 64'(valid_o), 64'(0));
        check("rst_ctrl", 64'(ctrl_o), 64'(0));
        check("rst_data", 64'(data_o), 64'(0));
        check("rst_stall", 64'(stall_cnt_o), 64'(0));
        sb.delete();
        exp_cnt = 0;
      end else begin
        check("ready_o", 64'(ready_o), 64'(sb.size() < 2));
        check("valid_o", 64'(valid_o), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
          check("ctrl_o", 64'(ctrl_o), 64'(sb[0].c));
          check("data_o", 64'(data_o), 64'(sb[0].d));
        end else begin
          check("bubble_ctrl", 64'(ctrl_o), 64'(0));
        end
        check("stall_cnt", 64'(stall_cnt_o), 64'(exp_cnt));
        if (sb.size() != 0 && !ready_i && exp_cnt < 15) exp_cnt++;
        room = (sb.size() < 2);
        if (flush_i) begin
          sb.delete();
        end else begin
          if (sb.size() != 0 && ready_i) void'(sb.pop_front());
          if (valid_i && room) sb.push_back('{c: ctrl_i, d: data_i});
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic r, input logic f, input logic [DW-1:0] d);
    valid_i = v;
    ready_i = r;
    flush_i = f;
    data_i  = d;
    ctrl_i  = CW'($urandom);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    flush_i = 1'b0;
    data_i  = '0;
    ctrl_i  = '0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);

    for (int i = 1; i <= 8; i++) cyc(1, 1, 0, DW'(i));
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);

    // Two words against a stalled sink, hold, then drain in order.
    cyc(1, 0, 0, 32'hAAAA_0001);
    cyc(1, 0, 0, 32'hBBBB_0002);
    cyc(1, 0, 0, 32'hCCCC_0003);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);

    // Refill to the skid state, then flush together with a new input word.
    cyc(1, 0, 0, 32'h1111_0001);
    cyc(1, 0, 0, 32'h2222_0002);
    cyc(1, 0, 1, 32'hDEAD_BEEF);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);

    // Saturation of the 4-bit stall counter.
    cyc(1, 0, 0, 32'h5A5A_5A5A);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
    check("stall_sat", 64'(stall_cnt_o), 64'(15));
    cyc(0, 0, 0, 0);
    check("stall_hold", 64'(stall_cnt_o), 64'(15));
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 19) == 0), DW'($urandom));
    end

    // Asynchronous reset between edges while holding a word.
    cyc(1, 0, 0, 32'h7777_0007);
    valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("async_valid", 64'(valid_o), 64'(0));
    check("async_ctrl", 64'(ctrl_o), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 32'h0000_0042);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pip_stage_elastic
`default_nettype wire
